// File: rtl/key_press_if.sv
// Button-side bundle of the key press conditioner: raw keys and freeze in,
// one-cycle press pulses and debounced held levels out.
interface key_press_if;
    logic key_l_n;
    logic key_r_n;
    logic freeze;
    logic L;
    logic R;
    logic l_held;
    logic r_held;

    modport master (
        output key_l_n, key_r_n, freeze,
        input  L, R, l_held, r_held
    );

    modport slave (
        input  key_l_n, key_r_n, freeze,
        output L, R, l_held, r_held
    );
endinterface

// File: rtl/key_press_conditioner.sv
// Two independent synchronise-and-debounce channels for the tug-of-war buttons;
// each accepted press yields exactly one registered single-cycle pulse.
module key_press_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input logic        clk,
    input logic        reset,
    key_press_if.slave bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DB_PRESS, HELD, DB_REL} state_t;

    logic [1:0] key_n;
    assign key_n = {bus.key_r_n, bus.key_l_n};

    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        logic          s1_p0;
        logic          s2_p1;
        logic          pressed;
        logic          accept;
        logic          pulse_p2;
        logic          held;
        state_t        state;
        state_t        state_nxt;
        logic [CW-1:0] cnt;
        logic [CW-1:0] cnt_nxt;

        // Stage p0/p1: two-flop synchroniser; reset forces "pressed" so a key
        // held through reset never produces a pulse.
        always_ff @(posedge clk) begin
            if (reset) begin
                s1_p0 <= 1'b0;
                s2_p1 <= 1'b0;
            end else begin
                s1_p0 <= key_n[ch];
                s2_p1 <= s1_p0;
            end
        end

        assign pressed = ~s2_p1;

        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            accept    = 1'b0;
            case (state)
                IDLE: begin
                    if (pressed) begin
                        state_nxt = DB_PRESS;
                        cnt_nxt   = '0;
                    end
                end
                DB_PRESS: begin
                    if (!pressed) begin
                        state_nxt = IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = HELD;
                        accept    = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!pressed) begin
                        state_nxt = DB_REL;
                        cnt_nxt   = '0;
                    end
                end
                DB_REL: begin
                    if (pressed) begin
                        state_nxt = HELD;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            endcase
        end

        // Stage p2: debounce state and the registered pulse. freeze only
        // matters at the moment of acceptance; a frozen press is dropped.
        always_ff @(posedge clk) begin
            if (reset) begin
                state    <= HELD;
                cnt      <= '0;
                pulse_p2 <= 1'b0;
            end else begin
                state    <= state_nxt;
                cnt      <= cnt_nxt;
                pulse_p2 <= accept & ~bus.freeze;
            end
        end

        assign held = (state == HELD) || (state == DB_REL);
    end

    assign bus.L      = g_chan[0].pulse_p2;
    assign bus.R      = g_chan[1].pulse_p2;
    assign bus.l_held = g_chan[0].held;
    assign bus.r_held = g_chan[1].held;
endmodule

// File: tb/tb_key_press_conditioner.sv
// Scoreboard bench for key_press_conditioner: a DEBOUNCE_CYCLES=4 instance
// and a DEBOUNCE_CYCLES=1 instance driven by directed button sequences.
module tb_key_press_conditioner;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    logic done = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    key_press_if bus_a ();
    key_press_if bus_b ();

    key_press_conditioner #(.DEBOUNCE_CYCLES(4)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    key_press_conditioner #(.DEBOUNCE_CYCLES(1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    typedef struct {
        int   cyc;
        logic l;
        logic r;
    } pulse_t;

    pulse_t pq [2][$];
    pulse_t lq [$];
    pulse_t e;
    int vectors = 0;
    int miscompares = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_pulse(input int d, input int at, input logic l, input logic r);
        pulse_t p;
        p.cyc = at; p.l = l; p.r = r;
        pq[d].push_back(p);
    endtask

    task automatic exp_held(input logic lh, input logic rh);
        pulse_t p;
        p.cyc = cyc; p.l = lh; p.r = rh;
        lq.push_back(p);
    endtask

    // Monitor: compares every pulse and held-level sample against the queues.
    always @(negedge clk) begin
        logic [1:0] gl;
        logic [1:0] gr;
        gl = {bus_b.L, bus_a.L};
        gr = {bus_b.R, bus_a.R};
        for (int d = 0; d < 2; d++) begin
            if (gl[d] || gr[d]) begin
                vectors++;
                if (pq[d].size() == 0) begin
                    miscompares++;
                    $display("FAIL pulse_dut%0d: unexpected L=%0b R=%0b at cycle %0d", d, gl[d], gr[d], cyc);
                end else begin
                    e = pq[d].pop_front();
                    if (e.cyc != cyc || e.l != gl[d] || e.r != gr[d]) begin
                        miscompares++;
                        $display("FAIL pulse_dut%0d: got cycle %0d L=%0b R=%0b, expected cycle %0d L=%0b R=%0b",
                                 d, cyc, gl[d], gr[d], e.cyc, e.l, e.r);
                    end
                end
            end else if (pq[d].size() != 0 && pq[d][0].cyc < cyc) begin
                vectors++;
                miscompares++;
                e = pq[d].pop_front();
                $display("FAIL pulse_dut%0d: missing pulse, expected at cycle %0d L=%0b R=%0b", d, e.cyc, e.l, e.r);
            end
        end
        while (lq.size() != 0 && lq[0].cyc <= cyc) begin
            e = lq.pop_front();
            vectors++;
            if (bus_a.l_held != e.l || bus_a.r_held != e.r) begin
                miscompares++;
                $display("FAIL held_levels: cycle %0d got l_held=%0b r_held=%0b, expected %0b %0b",
                         cyc, bus_a.l_held, bus_a.r_held, e.l, e.r);
            end
        end
        if (done) begin
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (pq[d].size() != 0) begin
                    miscompares++;
                    $display("FAIL pending_dut%0d: %0d expected pulses never seen, expected 0", d, pq[d].size());
                end
            end
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $finish;
        end
    end

    initial begin
        int k;
        bus_a.key_l_n = 1'b1; bus_a.key_r_n = 1'b1; bus_a.freeze = 1'b0;
        bus_b.key_l_n = 1'b1; bus_b.key_r_n = 1'b1; bus_b.freeze = 1'b0;
        reset = 1'b1;
        step(); step();
        exp_held(1'b1, 1'b1);
        reset = 1'b0;
        repeat (10) step();
        exp_held(1'b0, 1'b0);

        // Single left press: pulse 7 edges after the key falls
        k = cyc; bus_a.key_l_n = 1'b0; exp_pulse(0, k + 7, 1'b1, 1'b0);
        repeat (8) step();
        exp_held(1'b1, 1'b0);
        repeat (4) step();
        bus_a.key_l_n = 1'b1;
        repeat (10) step();
        exp_held(1'b0, 1'b0);

        // Bounce: never confirmed
        bus_a.key_l_n = 1'b0;
        repeat (2) begin step(); exp_held(1'b0, 1'b0); end
        bus_a.key_l_n = 1'b1;
        step(); exp_held(1'b0, 1'b0);
        bus_a.key_l_n = 1'b0;
        repeat (2) begin step(); exp_held(1'b0, 1'b0); end
        bus_a.key_l_n = 1'b1;
        repeat (10) begin step(); exp_held(1'b0, 1'b0); end

        // Simultaneous presses, long hold
        k = cyc; bus_a.key_l_n = 1'b0; bus_a.key_r_n = 1'b0;
        exp_pulse(0, k + 7, 1'b1, 1'b1);
        repeat (30) step();
        exp_held(1'b1, 1'b1);
        bus_a.key_l_n = 1'b1; bus_a.key_r_n = 1'b1;
        repeat (10) step();
        exp_held(1'b0, 1'b0);

        // Five press/release pairs
        for (int i = 0; i < 5; i++) begin
            k = cyc; bus_a.key_l_n = 1'b0; exp_pulse(0, k + 7, 1'b1, 1'b0);
            repeat (8) step();
            bus_a.key_l_n = 1'b1;
            repeat (8) step();
        end
        exp_held(1'b0, 1'b0);

        // Release glitch mid-hold: no second pulse
        k = cyc; bus_a.key_l_n = 1'b0; exp_pulse(0, k + 7, 1'b1, 1'b0);
        repeat (8) step();
        bus_a.key_l_n = 1'b1;
        repeat (2) step();
        bus_a.key_l_n = 1'b0;
        repeat (6) step();
        exp_held(1'b1, 1'b0);
        bus_a.key_l_n = 1'b1;
        repeat (10) step();
        exp_held(1'b0, 1'b0);

        // Freeze swallows the press even after it drops
        bus_a.freeze = 1'b1;
        bus_a.key_l_n = 1'b0;
        repeat (8) step();
        exp_held(1'b1, 1'b0);
        bus_a.freeze = 1'b0;
        repeat (4) step();
        bus_a.key_l_n = 1'b1;
        repeat (10) step();
        k = cyc; bus_a.key_l_n = 1'b0; exp_pulse(0, k + 7, 1'b1, 1'b0);
        repeat (8) step();
        bus_a.key_l_n = 1'b1;
        repeat (10) step();

        // Right key held across reset
        bus_a.key_r_n = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        repeat (2) step();
        exp_held(1'b1, 1'b1);
        reset = 1'b0;
        repeat (10) step();
        exp_held(1'b0, 1'b1);
        bus_a.key_r_n = 1'b1;
        repeat (10) step();
        k = cyc; bus_a.key_r_n = 1'b0; exp_pulse(0, k + 7, 1'b0, 1'b1);
        repeat (8) step();
        bus_a.key_r_n = 1'b1;
        repeat (10) step();
        exp_held(1'b0, 1'b0);

        // Reset asserted in the cycle R is high
        k = cyc; bus_a.key_r_n = 1'b0; exp_pulse(0, k + 7, 1'b0, 1'b1);
        repeat (7) step();
        reset = 1'b1;
        step();
        exp_held(1'b1, 1'b1);
        reset = 1'b0;
        bus_a.key_r_n = 1'b1;
        repeat (10) step();
        exp_held(1'b0, 1'b0);

        // DEBOUNCE_CYCLES=1 instance: pulse 4 edges after the key falls
        k = cyc; bus_b.key_l_n = 1'b0; exp_pulse(1, k + 4, 1'b1, 1'b0);
        repeat (12) step();
        bus_b.key_l_n = 1'b1;
        repeat (10) step();

        done = 1'b1;
    end
endmodule
